// File: rtl/la_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// la_ctrl_pkg
// Shared types and widths for the logic-analyzer input demultiplexer.
//   LA_WIDTH          width of one LA data word / one team slice
//   SEL_WIDTH         width of a team selector
//   la_demux_state_t  ROUTE (live data to one team) / GUARD (all slices zero)
//   la_sel_t          team selector
//   la_word_t         one LA data word
// ---------------------------------------------------------------------------
package la_ctrl_pkg;

  localparam int LA_WIDTH  = 128;
  localparam int SEL_WIDTH = 4;

  typedef enum logic {
    ROUTE = 1'b0,
    GUARD = 1'b1
  } la_demux_state_t;

  typedef logic [SEL_WIDTH-1:0] la_sel_t;
  typedef logic [LA_WIDTH-1:0]  la_word_t;

endpackage

// File: rtl/la_input_demux_if.sv
// ---------------------------------------------------------------------------
// la_input_demux_if
// Bundles the host LA inputs and the per-team fan-out of la_input_demux.
//   la_sel                   requested team index (raw, unqualified)
//   la_data_in               LA data word from the host
//   la_oenb                  per-bit host enable; 1 forces that bit to 0
//   designs_la_data_in_flat  slice i = bits [i*LA_WIDTH +: LA_WIDTH]
//   active_sel               team currently routed
//   switching                high while the guard window is active
// Modports: master = host side (drives LA inputs), slave = demux.
// ---------------------------------------------------------------------------
interface la_input_demux_if #(
  parameter int NUM_TEAMS = 12
) ();
  import la_ctrl_pkg::*;

  la_sel_t                              la_sel;
  la_word_t                             la_data_in;
  la_word_t                             la_oenb;
  logic [LA_WIDTH*(NUM_TEAMS+1)-1:0]    designs_la_data_in_flat;
  la_sel_t                              active_sel;
  logic                                 switching;

  modport master (
    output la_sel, la_data_in, la_oenb,
    input  designs_la_data_in_flat, active_sel, switching
  );

  modport slave (
    input  la_sel, la_data_in, la_oenb,
    output designs_la_data_in_flat, active_sel, switching
  );

endinterface

// File: rtl/la_sel_debounce.sv
// ---------------------------------------------------------------------------
// la_sel_debounce
// Qualifies the raw la_sel: a value must be sampled STABLE_CYCLES times in a
// row, be a valid team index and differ from the current target before it is
// accepted.
//   clk, nrst        clock, asynchronous active-low reset
//   la_sel_i         raw selector sample
//   target_i         selection the demux is heading to (pending or active)
//   accept_pulse_o   high for the cycle in which a new selection is accepted
//   accepted_sel_o   the selection being accepted
// ---------------------------------------------------------------------------
module la_sel_debounce
  import la_ctrl_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int NUM_TEAMS     = 12
) (
  input  logic    clk,
  input  logic    nrst,
  input  la_sel_t la_sel_i,
  input  la_sel_t target_i,
  output logic    accept_pulse_o,
  output la_sel_t accepted_sel_o
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam la_sel_t          MAX_SEL = la_sel_t'(NUM_TEAMS);

  la_sel_t          cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (la_sel_i != cand_q) begin
      cand_d = la_sel_i;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Acceptance is evaluated on the post-sample state. It stays asserted while a
  // qualified, valid candidate differs from the target, so a candidate that
  // loses to a guard expiry is picked up again on the next cycle.
  assign accept_pulse_o = (cnt_d == CNT_MAX) && (cand_d <= MAX_SEL) && (cand_d != target_i);
  assign accepted_sel_o = cand_d;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/la_input_demux.sv
// ---------------------------------------------------------------------------
// la_input_demux
// Routes the host LA input bus to exactly one team slice. Selection changes
// are debounced, then all slices are held at zero for GUARD_CYCLES before the
// new team goes live, so two teams never see live data in the same cycle.
//   clk, nrst   clock, asynchronous active-low reset
//   bus         la_input_demux_if.slave: la_sel, la_data_in, la_oenb in;
//               designs_la_data_in_flat, active_sel, switching out
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module la_input_demux
  import la_ctrl_pkg::*;
#(
  parameter int NUM_TEAMS     = 12,
  parameter int STABLE_CYCLES = 3,
  parameter int GUARD_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  la_input_demux_if.slave  bus
);

  localparam int                NUM_SLICES = NUM_TEAMS + 1;
  localparam int                FLAT_W     = LA_WIDTH * NUM_SLICES;
  localparam int                GCNT_W     = $clog2(GUARD_CYCLES + 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST  = GCNT_W'(GUARD_CYCLES - 1);

  la_demux_state_t   state_q, state_d;
  la_sel_t           active_q, active_d;
  la_sel_t           pending_q, pending_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              switching_q, switching_d;
  logic [FLAT_W-1:0] flat_q, flat_d;

  la_sel_t           target;
  logic              accept;
  la_sel_t           accepted_sel;

  // While guarding, a further change is compared against the pending team,
  // not the one that was routed before the switchover started.
  assign target = (state_q == GUARD) ? pending_q : active_q;

  la_sel_debounce #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .NUM_TEAMS     (NUM_TEAMS)
  ) u_debounce (
    .clk            (clk),
    .nrst           (nrst),
    .la_sel_i       (bus.la_sel),
    .target_i       (target),
    .accept_pulse_o (accept),
    .accepted_sel_o (accepted_sel)
  );

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pending_d   = pending_q;
    gcnt_d      = gcnt_q;
    switching_d = switching_q;
    unique case (state_q)
      ROUTE: begin
        if (accept) begin
          state_d     = GUARD;
          pending_d   = accepted_sel;
          gcnt_d      = '0;
          switching_d = 1'b1;
        end
      end
      GUARD: begin
        // Expiry takes priority over a simultaneous acceptance.
        if (gcnt_q == GCNT_LAST) begin
          state_d     = ROUTE;
          active_d    = pending_q;
          switching_d = 1'b0;
        end else if (accept) begin
          pending_d = accepted_sel;
          gcnt_d    = '0;
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end
      default: state_d = ROUTE;
    endcase
  end

  // Live data only flows while routing and not leaving ROUTE this cycle; the
  // first live word for a new team therefore lands one edge after expiry.
  always_comb begin
    flat_d = '0;
    if ((state_q == ROUTE) && !accept) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (active_q == la_sel_t'(i)) begin
          flat_d[i*LA_WIDTH +: LA_WIDTH] = bus.la_data_in & ~bus.la_oenb;
        end
      end
    end
  end

  // NOTE: the wide slice register is a set of output flops, not a storage
  // array, so it is reset like any other state to guarantee zero on all slices.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ROUTE;
      active_q    <= '0;
      pending_q   <= '0;
      gcnt_q      <= '0;
      switching_q <= 1'b0;
      flat_q      <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      gcnt_q      <= gcnt_d;
      switching_q <= switching_d;
      flat_q      <= flat_d;
    end
  end

  assign bus.designs_la_data_in_flat = flat_q;
  assign bus.active_sel              = active_q;
  assign bus.switching               = switching_q;

endmodule
